// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] FETCH_INC = 32'd4;

  typedef enum logic {IDLE, REQ} fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries with flush.
// The head entry is read straight out of the storage flops.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  fetch_entry_t             wr_data,
  input  logic                     rd_en,
  output fetch_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_rd;

  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  // The caller's credit scheme never writes when full, so no full guard here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      count <= count + (wr_en ? CNT_ONE : '0) - (do_rd ? CNT_ONE : '0);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues sequential word requests on a req/gnt/rvalid bus,
// buffers responses with their PC, and flushes/discards on redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        busy_o
);

  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CW_ONE = CW'(1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc, resp_pc, redir_pc, raddr;
  logic          redir_defer;
  logic [CW-1:0] outstanding, discard_cnt, out_nxt;
  logic [FCW-1:0] fifo_count;
  logic          pending, issue, gnt_ok, rsp_ok, pop, fifo_wr;
  fetch_entry_t  wr_entry, head;

  assign raddr   = redirect_addr_i & ~32'h3;
  assign pending = (state == REQ);
  assign pop     = instr_valid_o & instr_ready_i;

  // Buffered + live in-flight words must fit the FIFO. Written as
  // count + outstanding < DEPTH + discard + pop so the live count never goes
  // negative while a discarded request is still waiting for its grant.
  assign issue = !rst && fetch_en_i && !redirect_i &&
                 (32'(outstanding) < MAX_OUTSTANDING) &&
                 (32'(fifo_count) + 32'(outstanding) <
                  FIFO_DEPTH + 32'(discard_cnt) + 32'(pop));

  assign instr_req_o  = issue | pending;
  assign instr_addr_o = fetch_pc;
  assign gnt_ok       = instr_req_o & instr_gnt_i;
  assign rsp_ok       = instr_rvalid_i && (outstanding != '0);
  assign out_nxt      = outstanding + (gnt_ok ? CW_ONE : '0) - (rsp_ok ? CW_ONE : '0);
  assign fifo_wr      = rsp_ok && (discard_cnt == '0) && !redirect_i;
  assign busy_o       = (outstanding != '0) | instr_req_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_pc    <= BOOT_ADDR;
      resp_pc     <= BOOT_ADDR;
      redir_pc    <= BOOT_ADDR;
      redir_defer <= 1'b0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= out_nxt;
      state       <= (instr_req_o && !instr_gnt_i) ? REQ : IDLE;

      // An ungranted request holds its address; a redirect seen meanwhile
      // is parked and applied at the grant.
      if (gnt_ok) begin
        redir_defer <= 1'b0;
        if (redirect_i)       fetch_pc <= raddr;
        else if (redir_defer) fetch_pc <= redir_pc;
        else                  fetch_pc <= fetch_pc + FETCH_INC;
      end else if (redirect_i) begin
        if (pending) begin
          redir_pc    <= raddr;
          redir_defer <= 1'b1;
        end else begin
          fetch_pc <= raddr;
        end
      end

      if (redirect_i) begin
        resp_pc     <= raddr;
        discard_cnt <= out_nxt + ((pending && !instr_gnt_i) ? CW_ONE : '0);
      end else if (rsp_ok) begin
        if (discard_cnt != '0) discard_cnt <= discard_cnt - CW_ONE;
        else                   resp_pc     <= resp_pc + FETCH_INC;
      end
    end
  end

  assign wr_entry = '{pc: resp_pc, instr: instr_rdata_i};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_i),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count)
  );

  assign instr_valid_o = (fifo_count != '0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against
// a program-order reference model and an in-order memory model.
module tb_instr_fetch_unit;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0, redirect = 1'b0, ready = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        instr_req, instr_gnt, instr_valid, busy;
  logic        instr_rvalid = 1'b0;
  logic [31:0] instr_addr, instr, instr_pc;
  logic [31:0] instr_rdata = '0;

  int total = 0, bad = 0;
  int gnt_stall = 0, lat_max = 0, cyc = 0, last_due = 0, tb_out = 0;
  bit rand_mode = 1'b0;

  logic [31:0] words [64];
  logic [31:0] exp_pc, exp_fetch, defer_pc;
  bit          defer, prev_hold;
  logic [31:0] gaddr[$], gcyc[$], pop_pc[$], pop_ins[$], pop_cyc[$];

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  always #5 clk = ~clk;
  assign instr_gnt = instr_req && (gnt_stall == 0);

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_en_i      (fetch_en),
    .instr_req_o     (instr_req),
    .instr_addr_o    (instr_addr),
    .instr_gnt_i     (instr_gnt),
    .instr_rvalid_i  (instr_rvalid),
    .instr_rdata_i   (instr_rdata),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .instr_ready_i   (ready),
    .busy_o          (busy)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return words[a[7:2]];
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hdead_beef;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: model checks on pre-edge values, then memory update at negedge.
  task automatic tick();
    logic req_s, gnt_s, rv_s, pop_s, rd_s;
    logic [31:0] ra;
    int d;
    #1;
    req_s = instr_req; gnt_s = instr_gnt; rv_s = instr_rvalid;
    pop_s = instr_valid && ready; rd_s = redirect;
    ra = redirect_addr & ~32'h3;
    if (prev_hold) begin
      chk("hold_req", {31'd0, req_s}, 32'd1);
      chk("hold_addr", instr_addr, exp_fetch);
    end
    if (pop_s && !rd_s) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_instr", instr, word(exp_pc));
      pop_pc.push_back(instr_pc); pop_ins.push_back(instr); pop_cyc.push_back(cyc);
      exp_pc += 4;
    end
    if (rd_s) exp_pc = ra;
    if (req_s && gnt_s) begin
      chk("gnt_addr", instr_addr, exp_fetch);
      gaddr.push_back(instr_addr); gcyc.push_back(cyc);
      d = cyc + 1 + int'($urandom_range(0, lat_max));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: instr_addr, due: d});
      tb_out++;
      chk("max_outstanding", {31'd0, tb_out <= MAXO}, 32'd1);
      if (rd_s) exp_fetch = ra;
      else if (defer) exp_fetch = defer_pc;
      else exp_fetch += 4;
      defer = 1'b0;
    end else if (rd_s) begin
      if (req_s) begin defer = 1'b1; defer_pc = ra; end
      else exp_fetch = ra;
    end
    if (rv_s && tb_out > 0) tb_out--;
    prev_hold = req_s && !gnt_s;
    @(posedge clk);
    @(negedge clk);
    if (req_s && !gnt_s && gnt_stall > 0) gnt_stall--;
    if (rand_mode && req_s && gnt_s)
      gnt_stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    cyc++;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      instr_rvalid = 1'b1; instr_rdata = word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      instr_rvalid = 1'b0; instr_rdata = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; fetch_en = 1'b0; ready = 1'b0; redirect = 1'b0; gnt_stall = 0;
    instr_rvalid = 1'b0; instr_rdata = '0;
    mq.delete(); gaddr.delete(); gcyc.delete();
    pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
    exp_pc = '0; exp_fetch = '0; defer = 1'b0; defer_pc = '0; prev_hold = 1'b0;
    tb_out = 0; cyc = 0; last_due = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_pops();
    pop_pc.delete(); pop_ins.delete(); pop_cyc.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    words[0] = 32'd150; words[1] = 32'd3215; words[2] = 32'd2747; words[3] = 32'd251111;

    // reset values
    #1 rst = 1'b1;
    #2;
    chk("rst_req", {31'd0, instr_req}, 32'd0);
    chk("rst_addr", instr_addr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // 1: streaming
    do_reset();
    fetch_en = 1'b1; ready = 1'b1;
    repeat (7) tick();
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", qat(gaddr, i), 32'(4 * i));
      chk("t1_gcyc", qat(gcyc, i), 32'(i));
      chk("t1_pc", qat(pop_pc, i), 32'(4 * i));
      chk("t1_instr", qat(pop_ins, i), words[i]);
      chk("t1_pcyc", qat(pop_cyc, i), 32'(2 + i));
    end

    // 2: decode stalled from start
    do_reset();
    fetch_en = 1'b1; ready = 1'b0;
    repeat (5) tick();
    #1;
    chk("t2_ngnt", 32'(gaddr.size()), 32'd2);
    chk("t2_a1", qat(gaddr, 1), 32'd4);
    chk("t2_req_low", {31'd0, instr_req}, 32'd0);
    chk("t2_valid", {31'd0, instr_valid}, 32'd1);
    chk("t2_head", instr, 32'd150);
    ready = 1'b1;
    #1;
    chk("t2_req_on_pop", {31'd0, instr_req}, 32'd1);
    chk("t2_addr8", instr_addr, 32'd8);
    tick();
    #1;
    chk("t2_head2", instr, 32'd3215);
    chk("t2_head2_pc", instr_pc, 32'd4);
    repeat (4) tick();

    // 3: grant withheld on addr 4, fetch_en drops while waiting
    do_reset();
    fetch_en = 1'b1; ready = 1'b1;
    tick();
    gnt_stall = 3;
    tick();
    fetch_en = 1'b0;
    repeat (3) begin
      #1;
      chk("t3_req_held", {31'd0, instr_req}, 32'd1);
      chk("t3_addr_held", instr_addr, 32'd4);
      tick();
    end
    repeat (4) tick();
    #1;
    chk("t3_ngnt", 32'(gaddr.size()), 32'd2);
    chk("t3_req_off", {31'd0, instr_req}, 32'd0);
    chk("t3_busy_off", {31'd0, busy}, 32'd0);
    chk("t3_npop", 32'(pop_pc.size()), 32'd2);

    // 4: redirect coincides with rvalid of addr 4
    do_reset();
    fetch_en = 1'b1; ready = 1'b1;
    tick(); tick();
    clear_pops();
    redirect = 1'b1; redirect_addr = 32'h8;
    tick();
    redirect = 1'b0;
    repeat (6) tick();
    chk("t4_pc0", qat(pop_pc, 0), 32'd8);
    chk("t4_ins0", qat(pop_ins, 0), 32'd2747);
    chk("t4_ins1", qat(pop_ins, 1), 32'd251111);

    // 5: redirect while addr 12 waits for grant
    do_reset();
    fetch_en = 1'b1; ready = 1'b1;
    repeat (3) tick();
    gnt_stall = 3;
    tick();
    clear_pops();
    redirect = 1'b1; redirect_addr = 32'h0;
    #1;
    chk("t5_req_c4", {31'd0, instr_req}, 32'd1);
    chk("t5_addr_c4", instr_addr, 32'd12);
    tick();
    redirect = 1'b0;
    repeat (2) begin
      #1;
      chk("t5_req_held", {31'd0, instr_req}, 32'd1);
      chk("t5_addr_held", instr_addr, 32'd12);
      tick();
    end
    repeat (5) tick();
    chk("t5_g3", qat(gaddr, 3), 32'd12);
    chk("t5_g4", qat(gaddr, 4), 32'd0);
    chk("t5_pc0", qat(pop_pc, 0), 32'd0);
    chk("t5_ins0", qat(pop_ins, 0), 32'd150);

    // 6: async reset with FIFO full
    do_reset();
    fetch_en = 1'b1; ready = 1'b0;
    repeat (5) tick();
    ready = 1'b1;
    #1;
    chk("t6_pre_req", {31'd0, instr_req}, 32'd1);
    chk("t6_pre_busy", {31'd0, busy}, 32'd1);
    chk("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_req", {31'd0, instr_req}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_instr", instr, 32'd0);
    chk("t6_addr", instr_addr, 32'h0);
    do_reset();
    fetch_en = 1'b1; ready = 1'b1;
    repeat (6) tick();
    chk("t6_g0", qat(gaddr, 0), 32'd0);
    chk("t6_pc0", qat(pop_pc, 0), 32'd0);
    chk("t6_ins0", qat(pop_ins, 0), 32'd150);

    // randomized run: stalls, latency, backpressure, redirects
    do_reset();
    rand_mode = 1'b1; lat_max = 2;
    for (int n = 0; n < 3000; n++) begin
      fetch_en = ($urandom_range(0, 9) != 0);
      ready    = ($urandom_range(0, 9) < 7);
      if (!redirect && $urandom_range(0, 24) == 0) begin
        redirect = 1'b1; redirect_addr = $urandom & 32'h0000_00ff;
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    chk("rand_progress", {31'd0, pop_pc.size() > 300}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
